// File: rtl/pkt_fifo_pkg.sv
// Shared constants and entry layout for the packet FIFO.
// Default sizes plus the {eop, data} storage word.
package pkt_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_MAX_PKTS = 16;

  typedef struct packed {
    logic                 eop;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_ram.sv
// Packet FIFO storage: one synchronous write port,
// one asynchronous read port, contents never reset.
module fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO: words become readable only once their packet
// is committed by an eop write; aborted/overflowed packets roll back.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_PKTS = DEF_MAX_PKTS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_enable,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_eop,
  input  logic                       w_abort,
  input  logic                       r_enable,
  output logic [WIDTH-1:0]           r_data,
  output logic                       r_eop,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(MAX_PKTS):0]  pkt_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKTS) + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_try, wr_acc, commit;
  logic          rd_en, pop_eop;
  logic [WIDTH:0] ram_rdata;

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_q[AW-1:0]),
    .wdata({w_eop, w_data}),
    .raddr(rd_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  assign count     = wr_q - rd_q;
  assign pkt_count = pkt_q;
  assign empty     = (rd_q == cm_q);
  assign full      = (count == PW'(DEPTH))
                   | (pkt_q == CW'(MAX_PKTS));
  assign r_data    = empty ? '0 : ram_rdata[WIDTH-1:0];
  assign r_eop     = ~empty & ram_rdata[WIDTH];
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  always_comb begin
    wr_try  = w_enable & ~w_abort;
    wr_acc  = wr_try & ~full;
    rd_en   = r_enable & ~empty;
    pop_eop = rd_en & r_eop;
    ovf_d   = wr_try & full;
    udf_d   = r_enable & empty;
    wr_d    = wr_q;
    cm_d    = cm_q;
    drop_d  = drop_q;
    commit  = 1'b0;
    rd_d    = rd_en ? rd_q + PW'(1) : rd_q;
    // A dropped word poisons its packet until that packet's eop.
    if (w_abort) begin
      wr_d   = cm_q;
      drop_d = 1'b0;
    end else if (wr_try & w_eop & (drop_q | ovf_d)) begin
      wr_d   = cm_q;
      drop_d = 1'b0;
    end else if (wr_acc) begin
      wr_d = wr_q + PW'(1);
      if (w_eop) begin
        cm_d   = wr_q + PW'(1);
        commit = 1'b1;
      end
    end else if (ovf_d) begin
      drop_d = 1'b1;
    end
    unique case ({commit, pop_eop})
      2'b10:   pkt_d = pkt_q + CW'(1);
      2'b01:   pkt_d = pkt_q - CW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      pkt_q  <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

endmodule
